// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient to LO, remainder to HI.
// Quotient truncates toward zero; remainder carries the sign of the dividend.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic [1:0]       state_out
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [CW-1:0]    r_count;
    logic             r_qsign;
    logic             r_rsign;
    logic             r_busy;
    logic             r_done;
    logic             r_divZero;

    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic             w_bIsZero;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_trial;
    logic             w_trialOk;
    logic             w_busyNext;
    logic             w_doneNext;
    logic             w_divZeroNext;

    // Unsigned magnitudes; the most negative value maps onto itself as unsigned.
    assign w_absA    = A[WIDTH-1] ? (-A) : A;
    assign w_absB    = B[WIDTH-1] ? (-B) : B;
    assign w_bIsZero = (B == '0);

    assign w_shifted = {r_rem, r_quo[WIDTH-1]};
    assign w_trial   = w_shifted - {1'b0, r_divisor};
    assign w_trialOk = ~w_trial[WIDTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = w_bIsZero ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_count == '0) begin
                    w_next = FIX;
                end
            end
            FIX:     w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The divide-by-zero path is the only way to reach DONE straight from IDLE.
    always_comb begin
        w_busyNext    = (w_next == RUN) || (w_next == FIX);
        w_doneNext    = (w_next == DONE);
        w_divZeroNext = (w_next == DONE) && (r_state == IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_divZero <= 1'b0;
        end else begin
            r_busy    <= w_busyNext;
            r_done    <= w_doneNext;
            r_divZero <= w_divZeroNext;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_count   <= '0;
            r_qsign   <= 1'b0;
            r_rsign   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !w_bIsZero) begin
                        r_rem     <= '0;
                        r_quo     <= w_absA;
                        r_divisor <= w_absB;
                        r_qsign   <= A[WIDTH-1] ^ B[WIDTH-1];
                        r_rsign   <= A[WIDTH-1];
                        r_count   <= CW'(WIDTH - 1);
                    end
                end
                RUN: begin
                    r_rem   <= w_trialOk ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
                    r_quo   <= {r_quo[WIDTH-2:0], w_trialOk};
                    r_count <= r_count - 1'b1;
                end
                FIX: begin
                    r_lo <= r_qsign ? (-r_quo) : r_quo;
                    r_hi <= r_rsign ? (-r_rem) : r_rem;
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign div_zero  = r_divZero;
    assign HI        = r_hi;
    assign LO        = r_lo;
    assign state_out = r_state;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a cycle-level reference model compared every
// cycle, plus directed divisions with hand-computed quotient/remainder/latency.
module tb_div_unit;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [1:0]  state_out;

    int checks = 0;
    int errors = 0;

    div_unit #(.WIDTH(32)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .A         (A),
        .B         (B),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .HI        (HI),
        .LO        (LO),
        .state_out (state_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] modelQuo(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint q;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        q  = sa / sb;
        return q[31:0];
    endfunction

    function automatic logic [31:0] modelRem(input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = sa % sb;
        return r[31:0];
    endfunction

    // Reference model: cycles elapsed since a request was accepted.
    // 0 = idle, 1..32 = iterating, 33 = sign fix-up, 34 = result cycle.
    int          phase    = 0;
    bit          zeroPath = 1'b0;
    logic [31:0] expHi    = '0;
    logic [31:0] expLo    = '0;
    logic [31:0] pendHi   = '0;
    logic [31:0] pendLo   = '0;

    always @(posedge clock) begin
        if (reset) begin
            phase    <= 0;
            zeroPath <= 1'b0;
            expHi    <= '0;
            expLo    <= '0;
        end else if (phase == 0) begin
            if (start) begin
                if (B == 32'd0) begin
                    phase    <= 34;
                    zeroPath <= 1'b1;
                end else begin
                    phase    <= 1;
                    zeroPath <= 1'b0;
                    pendLo   <= modelQuo(A, B);
                    pendHi   <= modelRem(A, B);
                end
            end
        end else if (phase == 34) begin
            phase <= 0;
        end else begin
            phase <= phase + 1;
            if (phase == 33) begin
                expHi <= pendHi;
                expLo <= pendLo;
            end
        end
    end

    always @(negedge clock) begin
        logic [31:0] expState;
        expState = (phase == 0) ? 32'd0 : (phase <= 32) ? 32'd1 : (phase == 33) ? 32'd2 : 32'd3;
        checkOutput("model.state", {30'd0, state_out}, expState);
        checkOutput("model.busy", {31'd0, busy}, {31'd0, (phase >= 1 && phase <= 33)});
        checkOutput("model.done", {31'd0, done}, {31'd0, (phase == 34)});
        checkOutput("model.div_zero", {31'd0, div_zero}, {31'd0, (phase == 34 && zeroPath)});
        checkOutput("model.HI", HI, expHi);
        checkOutput("model.LO", LO, expLo);
    end

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        A     = a;
        B     = b;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        A     = $urandom();
        B     = $urandom();
    endtask

    // Called on the first negedge after acceptance; returns cycles until done.
    task automatic waitDone(input int pulseAt, output int lat);
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            start = (lat == pulseAt);
            @(negedge clock);
            lat++;
        end
        start = 1'b0;
    endtask

    task automatic runDiv(input string name, input logic [31:0] a, input logic [31:0] b,
                          input int pulseAt, input int expLat,
                          input logic [31:0] litLo, input logic [31:0] litHi, input logic litZero);
        int lat;
        applyStimulus(a, b);
        waitDone(pulseAt, lat);
        checkOutput({name, ".latency"}, lat, expLat);
        checkOutput({name, ".done"}, {31'd0, done}, 32'd1);
        checkOutput({name, ".div_zero"}, {31'd0, div_zero}, {31'd0, litZero});
        checkOutput({name, ".LO"}, LO, litLo);
        checkOutput({name, ".HI"}, HI, litHi);
    endtask

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (2) @(negedge clock);
        checkOutput("reset.state", {30'd0, state_out}, 32'd0);
        checkOutput("reset.busy", {31'd0, busy}, 32'd0);
        checkOutput("reset.HI", HI, 32'd0);
        checkOutput("reset.LO", LO, 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        runDiv("pos", 32'd100, 32'd7, 0, 34, 32'd14, 32'd2, 1'b0);
        runDiv("negA", 32'hFFFF_FF9C, 32'd7, 0, 34, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        runDiv("negB", 32'd100, 32'hFFFF_FFF9, 0, 34, 32'hFFFF_FFF2, 32'd2, 1'b0);
        runDiv("pos2", 32'd100, 32'd7, 0, 34, 32'd14, 32'd2, 1'b0);

        // Divide by zero: flag pulses with done, results untouched; start in DONE ignored.
        runDiv("zero", 32'd5, 32'd0, 0, 1, 32'd14, 32'd2, 1'b1);
        A     = 32'd9;
        B     = 32'd3;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        checkOutput("zero.after.state", {30'd0, state_out}, 32'd0);
        checkOutput("zero.after.busy", {31'd0, busy}, 32'd0);
        checkOutput("zero.after.done", {31'd0, done}, 32'd0);
        checkOutput("zero.after.div_zero", {31'd0, div_zero}, 32'd0);
        repeat (2) @(negedge clock);

        // Overflow case with a stray start pulse while iterating.
        runDiv("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 5, 34, 32'h8000_0000, 32'd0, 1'b0);
        runDiv("minByOne", 32'h8000_0000, 32'd1, 0, 34, 32'h8000_0000, 32'd0, 1'b0);
        runDiv("smallBig", 32'd3, 32'd10, 0, 34, 32'd0, 32'd3, 1'b0);
        runDiv("bothNeg", 32'hFFFF_FFF9, 32'hFFFF_FFFE, 0, 34, 32'd3, 32'hFFFF_FFFF, 1'b0);
        repeat (3) @(negedge clock);

        // Reset in the middle of an iteration aborts and clears results.
        applyStimulus(32'h1234_5678, 32'h11);
        for (int i = 1; i < 10; i++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort.state", {30'd0, state_out}, 32'd0);
        checkOutput("abort.busy", {31'd0, busy}, 32'd0);
        checkOutput("abort.HI", HI, 32'd0);
        checkOutput("abort.LO", LO, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        runDiv("postReset", 32'd9, 32'd3, 0, 34, 32'd3, 32'd0, 1'b0);
        repeat (3) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
